// File: rtl/spi_regmap_pkg.sv
// rtl/spi_regmap_pkg.sv - shared widths and FSM state encoding for the SPI register-map front end
package spi_regmap_pkg;
    localparam int ADDR_WIDTH  = 7;
    localparam int DATA_WIDTH  = 8;
    localparam int FRAME_WIDTH = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int RW_BIT      = FRAME_WIDTH - 1;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_RDATA,
        ST_DONE
    } state_t;
endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - N-stage single-bit synchroniser with a configurable reset value
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= {STAGES{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];
endmodule

// File: rtl/spi_frame_slave.sv
// rtl/spi_frame_slave.sv - oversampling SPI mode-0 slave that turns 16-bit frames into register strobes
module spi_frame_slave #(
    parameter int ADDR_WIDTH  = spi_regmap_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH  = spi_regmap_pkg::DATA_WIDTH,
    parameter int SYNC_STAGES = spi_regmap_pkg::SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sck_i,
    input  logic                  sdi_i,
    input  logic                  cs_ni,
    output logic                  sdo_o,
    output logic                  sdo_oe,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  frame_err,
    output logic                  busy
);
    import spi_regmap_pkg::*;

    localparam int         FW            = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int         CW            = 1 + ADDR_WIDTH;
    localparam logic [4:0] LAST_CMD_RISE = 5'(CW - 1);
    localparam logic [4:0] LAST_RISE     = 5'(FW - 1);

    logic w_sck, w_sdi, w_cs_n;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst(rst), .i_d(sck_i), .o_q(w_sck)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .rst(rst), .i_d(sdi_i), .o_q(w_sdi)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .i_d(cs_ni), .o_q(w_cs_n)
    );

    logic                  r_sck_d, r_cs_d, r_armed;
    logic [3:0]            r_flush;
    logic                  w_rise, w_fall, w_cs_fall, w_flushed;
    state_t                r_state, w_state_next;
    logic [4:0]            r_cnt;
    logic [FW-3:0]         r_shift;
    logic [FW-2:0]         w_shift_in;
    logic [DATA_WIDTH-1:0] r_tx;
    logic                  r_tx_loaded, r_rd_pend;
    logic                  r_sdo, r_wr_en, r_rd_en, r_frame_err;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  w_rd_fire, w_wr_fire, w_abort, w_shifting;

    assign w_rise     = w_sck & ~r_sck_d;
    assign w_fall     = ~w_sck & r_sck_d;
    assign w_cs_fall  = r_cs_d & ~w_cs_n;
    assign w_flushed  = (r_flush == 4'(SYNC_STAGES));
    assign w_shift_in = {r_shift, w_sdi};
    assign w_shifting = w_rise && (r_state == ST_CMD || r_state == ST_WDATA || r_state == ST_RDATA);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rd_fire    = 1'b0;
        w_wr_fire    = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_armed && w_cs_fall) w_state_next = ST_CMD;
            end
            ST_CMD: begin
                if (w_cs_n) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_rise && r_cnt == LAST_CMD_RISE) begin
                    if (w_shift_in[CW-1]) begin
                        w_rd_fire    = 1'b1;
                        w_state_next = ST_RDATA;
                    end else begin
                        w_state_next = ST_WDATA;
                    end
                end
            end
            ST_WDATA: begin
                if (w_cs_n) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_rise && r_cnt == LAST_RISE) begin
                    w_wr_fire    = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_RDATA: begin
                if (w_cs_n) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_rise && r_cnt == LAST_RISE) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_cs_n) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Frames are only accepted once CS has been seen high through a flushed
    // synchroniser, so a frame already running at reset release is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sck_d     <= 1'b0;
            r_cs_d      <= 1'b1;
            r_armed     <= 1'b0;
            r_flush     <= 4'd0;
            r_cnt       <= 5'd0;
            r_shift     <= '0;
            r_tx        <= '0;
            r_tx_loaded <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_sdo       <= 1'b0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_frame_err <= 1'b0;
            r_addr      <= '0;
            r_wr_data   <= '0;
        end else begin
            r_sck_d     <= w_sck;
            r_cs_d      <= w_cs_n;
            r_wr_en     <= w_wr_fire;
            r_rd_en     <= w_rd_fire;
            r_frame_err <= w_abort;
            r_rd_pend   <= r_rd_en;
            if (!w_flushed) r_flush <= r_flush + 4'd1;
            if (w_flushed && w_cs_n) r_armed <= 1'b1;

            if (r_state == ST_IDLE) begin
                r_cnt       <= 5'd0;
                r_shift     <= '0;
                r_tx_loaded <= 1'b0;
            end else if (w_shifting) begin
                r_cnt   <= r_cnt + 5'd1;
                r_shift <= w_shift_in[FW-3:0];
            end

            if (w_rd_fire) begin
                r_addr <= w_shift_in[ADDR_WIDTH-1:0];
            end
            if (w_wr_fire) begin
                r_addr    <= w_shift_in[FW-2:DATA_WIDTH];
                r_wr_data <= w_shift_in[DATA_WIDTH-1:0];
            end

            if (r_rd_pend && r_state == ST_RDATA) begin
                r_tx        <= rd_data;
                r_tx_loaded <= 1'b1;
            end else if (w_fall && r_tx_loaded && r_state == ST_RDATA) begin
                r_tx <= {r_tx[DATA_WIDTH-2:0], 1'b0};
            end

            if (w_state_next != ST_RDATA) begin
                r_sdo <= 1'b0;
            end else if (w_fall && r_tx_loaded && !r_rd_pend) begin
                r_sdo <= r_tx[DATA_WIDTH-1];
            end
        end
    end

    assign sdo_o     = r_sdo;
    assign sdo_oe    = ~w_cs_n;
    assign addr      = r_addr;
    assign wr_en     = r_wr_en;
    assign wr_data   = r_wr_data;
    assign rd_en     = r_rd_en;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != ST_IDLE);
endmodule
